alu_cmd_sequencer: RTL and testbench

Command front-end and result back-end for the ALU stage. It parses an 8-bit byte stream from the receive side into operand/function frames. It drives the ALU operand, function and enable inputs with the setup the ALU needs, then captures the 2×DATA_WIDTH result on the ALU's valid strobe. The result is returned low byte first over a valid/ready transmit handshake.

---
 rtl/alu_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command front-end and result back-end for the ALU stage.
// Optional partial-frame receive timeout: define ALU_SEQ_RX_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FUNC_WIDTH = 4,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic [DATA_WIDTH-1:0]   A,
  output logic [DATA_WIDTH-1:0]   B,
  output logic [FUNC_WIDTH-1:0]   ALU_FUNC,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    FRAME_ERR,
  output logic                    RX_DROP
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUNC, SETUP, EXEC, WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state, state_nx;
  logic                    err_nx;
  logic                    full_op;
  logic [DATA_WIDTH-1:0]   a_sh, b_sh;
  logic [2:0]              wait_cnt;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    busy_st;
  logic                    to_hit;

  assign busy_st = (state inside {SETUP, EXEC, WAIT, TX_LO, TX_HI});

`ifdef ALU_SEQ_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            in_get;

  assign in_get = (state inside {GET_A, GET_B, GET_FUNC});
  assign to_hit = in_get && !RX_VALID && (to_cnt == TO_W'(RX_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   to_cnt <= '0;
    else if (!in_get || RX_VALID) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      IDLE:
        if (RX_VALID) begin
          if (RX_DATA[7:0] == 8'hCC)      state_nx = GET_A;
          else if (RX_DATA[7:0] == 8'hDD) state_nx = GET_FUNC;
          else                            err_nx   = 1'b1;
        end
      GET_A:    if (RX_VALID) state_nx = GET_B;
      GET_B:    if (RX_VALID) state_nx = GET_FUNC;
      GET_FUNC: if (RX_VALID) state_nx = SETUP;
      SETUP:    state_nx = EXEC;
      EXEC:     state_nx = WAIT;
      WAIT:
        if (ALU_OUT_VALID) state_nx = TX_LO;
        else if (wait_cnt == 3'd3) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      TX_LO:    if (TX_READY) state_nx = TX_HI;
      TX_HI:    if (TX_READY) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (to_hit) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end
  end

  // Operands land in shadows and commit on FUNC, so an abandoned frame leaves A/B intact.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      A         <= '0;
      B         <= '0;
      ALU_FUNC  <= '0;
      ALU_EN    <= 1'b0;
      TX_DATA   <= '0;
      TX_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
      RX_DROP   <= 1'b0;
      full_op   <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      wait_cnt  <= '0;
      result    <= '0;
    end else begin
      ALU_EN    <= (state_nx == EXEC);
      TX_VALID  <= (state_nx inside {TX_LO, TX_HI});
      BUSY      <= (state_nx inside {SETUP, EXEC, WAIT, TX_LO, TX_HI});
      FRAME_ERR <= err_nx;
      RX_DROP   <= RX_VALID && busy_st;
      wait_cnt  <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
      case (state)
        IDLE:  if (RX_VALID) full_op <= (RX_DATA[7:0] == 8'hCC);
        GET_A: if (RX_VALID) a_sh <= RX_DATA;
        GET_B: if (RX_VALID) b_sh <= RX_DATA;
        GET_FUNC:
          if (RX_VALID) begin
            ALU_FUNC <= RX_DATA[FUNC_WIDTH-1:0];
            if (full_op) begin
              A <= a_sh;
              B <= b_sh;
            end
          end
        WAIT:
          if (ALU_OUT_VALID) begin
            result  <= ALU_OUT;
            TX_DATA <= ALU_OUT[DATA_WIDTH-1:0];
          end
        TX_LO: if (TX_READY) TX_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed frames, a small ALU stand-in,
// and a negedge monitor that checks every TX handshake against the expected-byte queue.
module tb_alu_cmd_sequencer;
  localparam int DW = 8;
  localparam int FW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RX_DATA = '0;
  logic          RX_VALID = 1'b0;
  logic [DW-1:0] A, B, TX_DATA;
  logic [FW-1:0] ALU_FUNC;
  logic          ALU_EN, TX_VALID, BUSY, FRAME_ERR, RX_DROP;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VALID;
  logic          TX_READY = 1'b0;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(.DATA_WIDTH(DW), .FUNC_WIDTH(FW), .RX_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .A(A), .B(B), .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .FRAME_ERR(FRAME_ERR), .RX_DROP(RX_DROP)
  );

  // ALU stand-in: result strobe two cycles after ALU_EN; 0 add, 1 sub, 2 mul, else 0.
  logic            alu_dead = 1'b0;
  logic            p1, p2;
  logic [2*DW-1:0] res;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p1 <= 1'b0; p2 <= 1'b0; res <= '0;
    end else begin
      p1 <= ALU_EN;
      p2 <= p1 && !alu_dead;
      if (ALU_EN)
        case (ALU_FUNC)
          4'd0:    res <= {8'h00, A} + {8'h00, B};
          4'd1:    res <= {8'h00, A} - {8'h00, B};
          4'd2:    res <= A * B;
          default: res <= '0;
        endcase
    end
  end
  assign ALU_OUT       = res;
  assign ALU_OUT_VALID = p2;

  logic [7:0] exp_q[$];
  int checks = 0, errors = 0, mchecks = 0, merrors = 0;

  // Monitor: handshake -> pop & compare; stalled TX must hold steady.
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;
  always @(negedge CLK) begin
    if (!RST) hold = 1'b0;
    else begin
      if (hold) begin
        mchecks++;
        if (!(TX_VALID && TX_DATA == hold_data)) begin
          merrors++;
          $display("FAIL tx_stable: got valid=%0b data=%02h, required valid=1 data=%02h", TX_VALID, TX_DATA, hold_data);
        end
      end
      if (TX_VALID && TX_READY) begin
        mchecks++;
        if (exp_q.size() == 0) begin
          merrors++;
          $display("FAIL tx_byte: got %02h, required no byte", TX_DATA);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (TX_DATA !== e) begin
            merrors++;
            $display("FAIL tx_byte: got %02h, required %02h", TX_DATA, e);
          end
        end
      end
      hold      = TX_VALID && !TX_READY;
      hold_data = TX_DATA;
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_DATA = b; RX_VALID = 1'b1;
    step();
    RX_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string n);
    int i;
    for (i = 0; i < 60 && (exp_q.size() != 0 || TX_VALID); i++) step();
    chk({n, "_drain"}, (exp_q.size() == 0 && !TX_VALID) ? 1 : 0, 1);
  endtask

  task automatic wait_txv(input string n);
    int i;
    for (i = 0; i < 60 && !TX_VALID; i++) step();
    chk({n, "_txv"}, TX_VALID, 1);
  endtask

  // Frame with TX_READY high; checks cycle-exact timing k+1..k+7.
  task automatic run_op(input string n, input logic full, input logic [7:0] a, b, f,
                        input logic [7:0] ea, eb, lo, hi);
    exp_q.push_back(lo); exp_q.push_back(hi);
    TX_READY = 1'b1;
    if (full) begin send(8'hCC); send(a); send(b); end
    else send(8'hDD);
    send(f);
    chk({n, "_setup"}, {A, B, 4'(ALU_FUNC), ALU_EN, BUSY}, {ea, eb, f[3:0], 1'b0, 1'b1});
    step(); chk({n, "_en_k2"}, ALU_EN, 1);
    step(); chk({n, "_en_k3"}, ALU_EN, 0);
    step(); chk({n, "_txv_k4"}, TX_VALID, 0);
    step(); chk({n, "_lo_k5"}, {TX_VALID, TX_DATA}, {1'b1, lo});
    step(); chk({n, "_hi_k6"}, {TX_VALID, TX_DATA}, {1'b1, hi});
    step(); chk({n, "_idle_k7"}, {BUSY, TX_VALID}, 2'b00);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_outs", {A, B, ALU_FUNC, TX_DATA, ALU_EN, TX_VALID, BUSY, FRAME_ERR, RX_DROP}, 0);
    RST = 1'b1;
    step();
    chk("rst_hold", {A, B, ALU_FUNC, TX_DATA, ALU_EN, TX_VALID, BUSY, FRAME_ERR, RX_DROP}, 0);

    run_op("mul", 1, 8'h0A, 8'h05, 8'h02, 8'h0A, 8'h05, 8'h32, 8'h00);
    run_op("reuse", 0, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h05, 8'h0F, 8'h00);

    // Backpressure: TX_READY low 10 cycles with the low byte pending.
    TX_READY = 1'b0;
    exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
    send(8'hCC); send(8'hFF); send(8'hFF); send(8'h02);
    wait_txv("stall");
    repeat (10) step();
    chk("stall_lo", {TX_VALID, TX_DATA}, {1'b1, 8'h01});
    TX_READY = 1'b1;
    wait_drain("stall");

    // Bad header.
    step();
    send(8'h55);
    chk("hdr_err", {FRAME_ERR, BUSY}, 2'b10);
    step(); chk("hdr_err_1cyc", FRAME_ERR, 0);

    // Byte during WAIT is dropped.
    exp_q.push_back(8'h06); exp_q.push_back(8'h00);
    send(8'hCC); send(8'h02); send(8'h03); send(8'h02);
    step(); step();
    send(8'h33);
    chk("drop_pulse", RX_DROP, 1);
    wait_drain("drop");
    chk("drop_once", RX_DROP, 0);

    // No ALU strobe: abort out of WAIT.
    alu_dead = 1'b1;
    send(8'hCC); send(8'h01); send(8'h01); send(8'h00);
    repeat (5) step();
    chk("wto_k6", FRAME_ERR, 0);
    step(); chk("wto_k7", {FRAME_ERR, BUSY, TX_VALID}, 3'b100);
    step(); chk("wto_k8", FRAME_ERR, 0);
    alu_dead = 1'b0;
    chk("wto_nosend", exp_q.size(), 0);

    // Partial frame then silence.
    send(8'hCC); send(8'h09);
`ifdef ALU_SEQ_RX_TIMEOUT_EN
    repeat (15) step();
    chk("rxto_early", FRAME_ERR, 0);
    step(); chk("rxto_err", FRAME_ERR, 1);
    chk("rxto_a_kept", A, 8'h01);
    step();
    send(8'h55);
    chk("rxto_idle", FRAME_ERR, 1);
`else
    repeat (40) step();
    chk("rxto_none", {FRAME_ERR, BUSY}, 2'b00);
    exp_q.push_back(8'h0B); exp_q.push_back(8'h00);
    send(8'h02); send(8'h00);
    wait_drain("rxto");
    chk("rxto_a", A, 8'h09);
`endif

    // Reset during TX_HI abandons the high byte.
    TX_READY = 1'b0;
    exp_q.push_back(8'h07);
    send(8'hCC); send(8'h03); send(8'h04); send(8'h00);
    wait_txv("rst_tx");
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    chk("rst_in_hi", {TX_VALID, TX_DATA}, {1'b1, 8'h00});
    RST = 1'b0;
    #1;
    chk("rst_async", {A, B, ALU_FUNC, TX_DATA, ALU_EN, TX_VALID, BUSY, FRAME_ERR, RX_DROP}, 0);
    step(); step();
    RST = 1'b1;
    repeat (3) step();
    chk("rst_nopartial", {TX_VALID, 8'(exp_q.size())}, 0);
    run_op("post_rst", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (3) step();
    checks = checks + mchecks;
    errors = errors + merrors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
